// File: rtl/franken_dmem_ctrl.sv
`timescale 1ns/1ps
// Data-memory controller: posted DEPTH-entry store buffer in front of a single-port req/ack word bus.
// Loads drain matching stores, then read the bus (read_valid one cycle after ack); stall holds the core.
module franken_dmem_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mem_write,
    input  logic                   mem_read,
    input  logic [AW-1:0]          address,
    input  logic [3:0]             byte_enable,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   read_valid,
    output logic                   stall,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [AW-1:0]          bus_addr,
    output logic [3:0]             bus_be,
    output logic [31:0]            bus_wdata,
    input  logic                   bus_ack,
    input  logic [31:0]            bus_rdata,
    output logic [$clog2(DEPTH):0] buf_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = AW - 2;

    typedef enum logic [1:0] {IDLE, WR, RD, RESP} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] fifo_addr_q [DEPTH];
    logic [3:0]    fifo_be_q   [DEPTH];
    logic [31:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;

    logic          bus_req_q, bus_req_d;
    logic          bus_we_q, bus_we_d;
    logic [AW-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [31:0]   read_data_q, read_data_d;
    logic          read_valid_q, read_valid_d;

    logic          full, empty, push, pop, ack, load_req, hit;
    logic [WW-1:0] word_addr;
    logic [PW-1:0] slot_off;
    logic          addr_lsb_unused;

    assign word_addr       = address[AW-1:2];
    assign addr_lsb_unused = ^address[1:0];
    assign full            = (count_q == (PW+1)'(DEPTH));
    assign empty           = (count_q == '0);
    assign push            = mem_write & ~full;
    assign ack             = bus_ack & bus_req_q;
    assign pop             = (state_q == WR) & ack;
    // A simultaneous store wins; the load is dropped for that cycle.
    assign load_req        = mem_read & ~mem_write;

    // Slot i is live when its distance from the head is below the occupancy.
    always_comb begin
        hit      = 1'b0;
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PW'(i) - rd_ptr_q;
            if (({1'b0, slot_off} < count_q) && (fifo_addr_q[i] == word_addr))
                hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= word_addr;
            fifo_be_q[wr_ptr_q]   <= byte_enable;
            fifo_data_q[wr_ptr_q] <= write_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load_req && !hit) state_d = RD;
                else if (!empty)      state_d = WR;
            end
            WR:      if (ack) state_d = IDLE;
            RD:      if (ack) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus fields are loaded on leaving IDLE and held until the ack edge.
    always_comb begin
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        read_data_d  = read_data_q;
        read_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (state_d == RD) begin
                    bus_req_d  = 1'b1;
                    bus_we_d   = 1'b0;
                    bus_addr_d = {word_addr, 2'b00};
                    bus_be_d   = 4'b1111;
                end else if (state_d == WR) begin
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b1;
                    bus_addr_d  = {fifo_addr_q[rd_ptr_q], 2'b00};
                    bus_be_d    = fifo_be_q[rd_ptr_q];
                    bus_wdata_d = fifo_data_q[rd_ptr_q];
                end
            end
            WR: if (ack) bus_req_d = 1'b0;
            RD: begin
                if (ack) begin
                    bus_req_d    = 1'b0;
                    read_data_d  = bus_rdata;
                    read_valid_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            read_data_q  <= read_data_d;
            read_valid_q <= read_valid_d;
        end
    end

    assign stall      = (mem_write & full) | (mem_read & ~read_valid_q);
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign buf_count  = count_q;

endmodule

// File: tb/tb_franken_dmem_ctrl.sv
`timescale 1ns/1ps
// Bench for franken_dmem_ctrl: directed scenarios plus a randomized core/bus run
// checked against an architectural memory model and an in-order store queue.
module tb_franken_dmem_ctrl;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mem_write = 1'b0, mem_read = 1'b0;
    logic [AW-1:0] address = '0;
    logic [3:0]    byte_enable = '0;
    logic [31:0]   write_data = '0;
    logic [31:0]   read_data;
    logic          read_valid, stall, bus_req, bus_we;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_be;
    logic [31:0]   bus_wdata;
    logic          bus_ack = 1'b0;
    logic [31:0]   bus_rdata = '0;
    logic [CW-1:0] buf_count;

    franken_dmem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
        .address(address), .byte_enable(byte_enable), .write_data(write_data),
        .read_data(read_data), .read_valid(read_valid), .stall(stall),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .buf_count(buf_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } xfer_t;

    int total = 0;
    int bad   = 0;
    bit auto_ack = 1'b0;
    int ack_wait = 0;
    int max_wait = 0;

    logic [31:0] slave_mem [int unsigned];
    logic [31:0] arch_mem  [int unsigned];
    xfer_t       xfer_q [$];
    xfer_t       exp_q  [$];
    xfer_t       mon_x;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] slave_word(input logic [31:0] a);
        int unsigned k = a[31:2];
        return slave_mem.exists(k) ? slave_mem[k] : 32'h0;
    endfunction

    function automatic logic [31:0] arch_word(input logic [31:0] a);
        int unsigned k = a[31:2];
        return arch_mem.exists(k) ? arch_mem[k] : 32'h0;
    endfunction

    // Bus slave memory and transfer log, updated on each completing transfer.
    always @(negedge clk) begin
        if (reset && bus_req && bus_ack) begin
            mon_x = '{bus_we, bus_addr, bus_be, (bus_we ? bus_wdata : bus_rdata)};
            xfer_q.push_back(mon_x);
            if (bus_we) slave_mem[bus_addr[31:2]] = merge(slave_word(bus_addr), bus_wdata, bus_be);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_ack) begin
            if (bus_ack) bus_ack = 1'b0;
            else if (bus_req) begin
                if (ack_wait == 0) begin
                    bus_ack   = 1'b1;
                    bus_rdata = bus_we ? $urandom : slave_word(bus_addr);
                    ack_wait  = $urandom_range(0, max_wait);
                end else ack_wait--;
            end
        end
    endtask

    task automatic apply_reset();
        mem_write = 0; mem_read = 0; address = '0; byte_enable = '0; write_data = '0;
        bus_ack = 0; bus_rdata = '0; auto_ack = 0; ack_wait = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        int n;
        bit seen;
        apply_reset();
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_bus_req: got %b want 0", bus_req); end
        total++; if (buf_count !== '0) begin bad++; $display("FAIL rst_count: got %0d want 0", buf_count); end
        total++; if (read_valid !== 1'b0 || read_data !== 32'h0) begin bad++; $display("FAIL rst_read: got rv=%b rd=%h want 0/0", read_valid, read_data); end
        total++; if (bus_we !== 1'b0 || bus_addr !== '0 || bus_be !== '0 || bus_wdata !== '0) begin bad++; $display("FAIL rst_bus_fields: got we=%b a=%h be=%h d=%h want zeros", bus_we, bus_addr, bus_be, bus_wdata); end
        step(); mem_write = 1; address = 32'h40; byte_enable = 4'hF; write_data = 32'h1111_2222;
        step(); mem_write = 0;
        n = 0;
        while (bus_req !== 1'b1 && n < 10) begin step(); n++; end
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL rst_wr_start: got bus_req=%b want 1", bus_req); end
        @(negedge clk); reset = 1'b0; #1;
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL rst_mid_wr_req: got %b want 0", bus_req); end
        total++; if (buf_count !== '0) begin bad++; $display("FAIL rst_mid_wr_count: got %0d want 0", buf_count); end
        total++; if (read_valid !== 1'b0 || bus_addr !== '0) begin bad++; $display("FAIL rst_mid_wr_out: got rv=%b a=%h want 0/0", read_valid, bus_addr); end
        @(negedge clk); reset = 1'b1;
        seen = 0;
        repeat (6) begin step(); if (bus_req) seen = 1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_discard: got bus activity=%b want 0", seen); end
    endtask

    task automatic test_full_stall();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            step(); mem_write = 1; address = 32'h200 + 32'(4*i); byte_enable = 4'hF; write_data = 32'hA000_0000 + 32'(i);
        end
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL full_stall: got %b want 1", stall); end
        total++; if (buf_count !== CW'(4)) begin bad++; $display("FAIL full_count: got %0d want 4", buf_count); end
        total++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h200) begin bad++; $display("FAIL full_head: got req=%b we=%b a=%h want 1/1/200", bus_req, bus_we, bus_addr); end
        repeat (2) step();
        @(negedge clk);
        total++; if (buf_count !== CW'(4) || stall !== 1'b1) begin bad++; $display("FAIL full_hold: got cnt=%0d stall=%b want 4/1", buf_count, stall); end
        step(); bus_ack = 1;
        @(negedge clk);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL full_ack_cycle_stall: got %b want 1", stall); end
        step(); bus_ack = 0;
        @(negedge clk);
        total++; if (buf_count !== CW'(3) || stall !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL full_after_pop: got cnt=%0d stall=%b req=%b want 3/0/0", buf_count, stall, bus_req); end
        step(); mem_write = 0;
        @(negedge clk);
        total++; if (buf_count !== CW'(4)) begin bad++; $display("FAIL full_fifth_push: got %0d want 4", buf_count); end
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'h204) begin bad++; $display("FAIL full_next_head: got req=%b a=%h want 1/204", bus_req, bus_addr); end
    endtask

    task automatic test_store_load_order();
        int start, pulses;
        logic [31:0] rd;
        apply_reset(); auto_ack = 1; max_wait = 2;
        start = xfer_q.size(); pulses = 0; rd = '0;
        step(); mem_write = 1; address = 32'h100; byte_enable = 4'hF; write_data = 32'hDEAD_BEEF;
        step(); mem_write = 0; mem_read = 1;
        repeat (40) begin
            @(negedge clk);
            if (read_valid) begin pulses++; rd = read_data; end
            step();
            if (pulses > 0) mem_read = 0;
        end
        mem_read = 0;
        total++; if (pulses !== 1) begin bad++; $display("FAIL order_pulses: got %0d want 1", pulses); end
        total++; if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL order_rdata: got %h want deadbeef", rd); end
        total++; if (xfer_q.size() - start !== 2) begin bad++; $display("FAIL order_xfers: got %0d want 2", xfer_q.size() - start); end
        else begin
            total++; if (xfer_q[start].we !== 1'b1 || xfer_q[start+1].we !== 1'b0) begin bad++; $display("FAIL order_seq: got we %b,%b want 1,0", xfer_q[start].we, xfer_q[start+1].we); end
        end
    endtask

    task automatic test_load_bypass();
        apply_reset();
        step(); mem_write = 1; address = 32'h200; byte_enable = 4'hF; write_data = 32'h55;
        step(); mem_write = 0; mem_read = 1; address = 32'h104;
        step();
        @(negedge clk);
        total++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h104 || bus_be !== 4'hF) begin bad++; $display("FAIL bypass_rd: got req=%b we=%b a=%h be=%h want 1/0/104/f", bus_req, bus_we, bus_addr, bus_be); end
        total++; if (buf_count !== CW'(1)) begin bad++; $display("FAIL bypass_count: got %0d want 1", buf_count); end
        step(); bus_ack = 1; bus_rdata = 32'hCAFE_F00D;
        step(); bus_ack = 0;
        @(negedge clk);
        total++; if (read_valid !== 1'b1 || read_data !== 32'hCAFE_F00D) begin bad++; $display("FAIL bypass_resp: got rv=%b rd=%h want 1/cafef00d", read_valid, read_data); end
        step(); mem_read = 0;
        step();
        @(negedge clk);
        total++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h200) begin bad++; $display("FAIL bypass_drain: got req=%b we=%b a=%h want 1/1/200", bus_req, bus_we, bus_addr); end
    endtask

    task automatic test_load_latency();
        apply_reset();
        step(); mem_read = 1; address = 32'h503;
        @(negedge clk);
        total++; if (stall !== 1'b1 || bus_req !== 1'b0) begin bad++; $display("FAIL lat_c0: got stall=%b req=%b want 1/0", stall, bus_req); end
        step();
        @(negedge clk);
        total++; if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_addr !== 32'h500 || bus_be !== 4'hF) begin bad++; $display("FAIL lat_c1: got req=%b we=%b a=%h be=%h want 1/0/500/f", bus_req, bus_we, bus_addr, bus_be); end
        step(); step(); bus_ack = 1; bus_rdata = 32'h1357_9BDF;
        @(negedge clk);
        total++; if (read_valid !== 1'b0) begin bad++; $display("FAIL lat_ack_cycle: got rv=%b want 0", read_valid); end
        step(); bus_ack = 0;
        @(negedge clk);
        total++; if (read_valid !== 1'b1 || read_data !== 32'h1357_9BDF || stall !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL lat_resp: got rv=%b rd=%h stall=%b req=%b want 1/13579bdf/0/0", read_valid, read_data, stall, bus_req); end
        step(); mem_read = 0;
        @(negedge clk);
        total++; if (read_valid !== 1'b0 || read_data !== 32'h1357_9BDF) begin bad++; $display("FAIL lat_hold: got rv=%b rd=%h want 0/13579bdf", read_valid, read_data); end
        step(); bus_ack = 1; bus_rdata = 32'hFFFF_0000;
        step(); bus_ack = 0;
        @(negedge clk);
        total++; if (read_valid !== 1'b0 || read_data !== 32'h1357_9BDF || bus_req !== 1'b0) begin bad++; $display("FAIL lat_stray_ack: got rv=%b rd=%h req=%b want 0/13579bdf/0", read_valid, read_data, bus_req); end
    endtask

    task automatic test_byte_store();
        apply_reset();
        step(); mem_write = 1; address = 32'h302; byte_enable = 4'b0100; write_data = 32'h00AB_0000;
        step(); mem_write = 0;
        step();
        @(negedge clk);
        total++; if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h300 || bus_be !== 4'b0100 || bus_wdata !== 32'h00AB_0000) begin bad++; $display("FAIL sb_fields: got req=%b we=%b a=%h be=%b d=%h want 1/1/300/0100/00ab0000", bus_req, bus_we, bus_addr, bus_be, bus_wdata); end
        step();
        @(negedge clk);
        total++; if (bus_req !== 1'b1 || bus_addr !== 32'h300 || bus_be !== 4'b0100 || bus_wdata !== 32'h00AB_0000) begin bad++; $display("FAIL sb_stable: got req=%b a=%h be=%b d=%h", bus_req, bus_addr, bus_be, bus_wdata); end
        step(); bus_ack = 1;
        step(); bus_ack = 0;
        @(negedge clk);
        total++; if (bus_req !== 1'b0 || buf_count !== '0) begin bad++; $display("FAIL sb_done: got req=%b cnt=%0d want 0/0", bus_req, buf_count); end
    endtask

    task automatic test_simultaneous();
        int start;
        bit saw_rd, saw_rv;
        apply_reset(); auto_ack = 1; max_wait = 1;
        start = xfer_q.size(); saw_rd = 0; saw_rv = 0;
        step(); mem_write = 1; mem_read = 1; address = 32'h600; byte_enable = 4'hF; write_data = 32'h600D;
        step(); mem_write = 0; mem_read = 0;
        @(negedge clk);
        total++; if (buf_count !== CW'(1)) begin bad++; $display("FAIL simul_push: got %0d want 1", buf_count); end
        repeat (8) begin
            step();
            @(negedge clk);
            if (bus_req && !bus_we) saw_rd = 1;
            if (read_valid) saw_rv = 1;
        end
        total++; if (saw_rd !== 1'b0 || saw_rv !== 1'b0) begin bad++; $display("FAIL simul_no_load: got rd=%b rv=%b want 0/0", saw_rd, saw_rv); end
        total++; if (xfer_q.size() - start !== 1) begin bad++; $display("FAIL simul_xfers: got %0d want 1", xfer_q.size() - start); end
    endtask

    task automatic test_random();
        int mcnt = 0, cyc = 0, wait_ld = 0, r;
        bit drain = 0, push, pop, ld_done, exp_stall;
        logic [31:0] exp_rd;
        xfer_t x;
        apply_reset(); auto_ack = 1; max_wait = 3;
        exp_q.delete();
        step();
        while (cyc < 1500) begin
            if (!mem_write && !mem_read && !drain) begin
                r = $urandom_range(0, 9);
                address = 32'h1000 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
                if (r < 5) begin
                    mem_write = 1; byte_enable = 4'($urandom_range(1, 15)); write_data = $urandom;
                end else if (r < 8) mem_read = 1;
            end
            @(negedge clk);
            total++; if (buf_count !== CW'(mcnt)) begin bad++; $display("FAIL rnd_count: cyc %0d got %0d want %0d", cyc, buf_count, mcnt); end
            push = 0; pop = 0; ld_done = 0;
            if (mem_write) begin
                exp_stall = (mcnt == DEPTH);
                total++; if (stall !== exp_stall) begin bad++; $display("FAIL rnd_stall: cyc %0d got %b want %b", cyc, stall, exp_stall); end
                if (mcnt < DEPTH) begin
                    push = 1;
                    arch_mem[address[31:2]] = merge(arch_word(address), write_data, byte_enable);
                    exp_q.push_back('{1'b1, {address[31:2], 2'b00}, byte_enable, write_data});
                end
            end
            if (bus_req && bus_ack && bus_we) begin
                total++;
                if (exp_q.size() == 0) begin bad++; $display("FAIL rnd_wr_extra: cyc %0d got write a=%h want none", cyc, bus_addr); end
                else begin
                    x = exp_q.pop_front(); pop = 1;
                    if (bus_addr !== x.addr || bus_be !== x.be || bus_wdata !== x.data) begin
                        bad++; $display("FAIL rnd_wr_order: cyc %0d got a=%h be=%h d=%h want a=%h be=%h d=%h", cyc, bus_addr, bus_be, bus_wdata, x.addr, x.be, x.data);
                    end
                end
            end
            if (mem_read && read_valid) begin
                exp_rd = arch_word(address);
                total++; if (read_data !== exp_rd) begin bad++; $display("FAIL rnd_load: cyc %0d a=%h got %h want %h", cyc, address, read_data, exp_rd); end
                ld_done = 1; wait_ld = 0;
            end else if (mem_read) begin
                wait_ld++;
                if (wait_ld > 100) begin total++; bad++; $display("FAIL rnd_load_timeout: a=%h got no read_valid want pulse", address); ld_done = 1; wait_ld = 0; end
            end
            mcnt = mcnt + int'(push) - int'(pop);
            step();
            if (push) mem_write = 0;
            if (ld_done) mem_read = 0;
            cyc++;
            if (cyc == 1200) drain = 1;
            if (drain && !mem_write && !mem_read && mcnt == 0) break;
        end
        total++; if (mcnt != 0 || exp_q.size() != 0) begin bad++; $display("FAIL rnd_drain: got %0d stores pending want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_full_stall();
        test_store_load_order();
        test_load_bypass();
        test_load_latency();
        test_byte_store();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
